// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decoding helpers.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational two's-complement conditional negate: out = neg ? -in : in.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         neg,
  output logic [W-1:0] out
);

  logic [W-1:0] inv;

  for (genvar gi = 0; gi < W; gi++) begin : g_inv
    assign inv[gi] = in[gi] ^ neg;
  end

  assign out = inv + {{(W-1){1'b0}}, neg};

endmodule

// File: rtl/mul_div_unit.sv
// WIDTH-generic multicycle multiply/divide unit producing HI/LO results:
// radix-2 shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               div_zero_reg;

  // Operand magnitudes for the load cycle
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = op_is_signed(op) & a[WIDTH-1];
  assign b_neg = op_is_signed(op) & b[WIDTH-1];

  mdu_signfix #(.W(WIDTH)) u_a_fix (.in(a), .neg(a_neg), .out(a_mag));
  mdu_signfix #(.W(WIDTH)) u_b_fix (.in(b), .neg(b_neg), .out(b_mag));

  // Multiply step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_addend = acc_reg[0] ? opnd_reg : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_reg[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_trial = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, opnd_reg};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign div_next  = {div_rem, acc_reg[WIDTH-2:0], div_ok};

  // Result sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic [WIDTH-1:0]   rem_signed;

  mdu_signfix #(.W(2*WIDTH)) u_prod_fix (
    .in(acc_reg), .neg(neg_q_reg), .out(prod_signed)
  );
  mdu_signfix #(.W(WIDTH)) u_quot_fix (
    .in(acc_reg[WIDTH-1:0]), .neg(neg_q_reg), .out(quot_signed)
  );
  mdu_signfix #(.W(WIDTH)) u_rem_fix (
    .in(acc_reg[2*WIDTH-1:WIDTH]), .neg(neg_r_reg), .out(rem_signed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      opnd_reg     <= '0;
      acc_reg      <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            is_div_reg <= op_is_div(op);
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            if (op_is_div(op) && (b == '0)) begin
              // Divide by zero: flag it and leave hi/lo untouched
              state_reg    <= S_DONE;
              done_reg     <= 1'b1;
              div_zero_reg <= 1'b1;
            end else begin
              state_reg <= S_CALC;
              if (op_is_div(op)) begin
                opnd_reg <= b_mag;
                acc_reg  <= {{WIDTH{1'b0}}, a_mag};
              end else begin
                opnd_reg <= a_mag;
                acc_reg  <= {{WIDTH{1'b0}}, b_mag};
              end
            end
          end
        end
        S_CALC: begin
          acc_reg <= is_div_reg ? div_next : mul_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_signed;
            lo_reg <= quot_signed;
          end else begin
            hi_reg <= prod_signed[2*WIDTH-1:WIDTH];
            lo_reg <= prod_signed[WIDTH-1:0];
          end
          state_reg <= S_DONE;
          done_reg  <= 1'b1;
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH = 32.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int tests = 0;
  int fails = 0;

  int lat;
  bit dz;
  bit busy_ok;
  bit seen_done;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one operation in the cycle after the current one and waits for done.
  // lat counts cycles after the start edge (first cycle = 1); -1 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit pester, output int l, output bit z, output bit bz);
    l  = -1;
    z  = 1'b0;
    bz = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (pester) begin
        start = (n >= 3 && n <= 6);
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      end
      bz = bz & busy;
      if (done) begin
        l = n + 1;
        z = div_zero;
        start = 1'b0;
        break;
      end
    end
    $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d latency=%0d", o, av, bv, hi, lo, z, l);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dz", {63'd0, div_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, dz, busy_ok);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_latency", 64'(lat), 64'd34);
    check("mult_busy", {63'd0, busy_ok}, 64'd1);
    check("mult_dz", {63'd0, dz}, 64'd0);
    @(posedge clk); #1;
    check("after_done_done", {63'd0, done}, 64'd0);
    check("after_done_busy", {63'd0, busy}, 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, dz, busy_ok);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 1'b0, lat, dz, busy_ok);
    check("mult_negneg", {hi, lo}, 64'h0000_0000_0000_0014);

    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, dz, busy_ok);
    check("div_neg_dividend", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd7, 32'd2, 1'b0, lat, dz, busy_ok);
    check("divu_b2b", {hi, lo}, 64'h0000_0001_0000_0003);
    check("divu_b2b_latency", 64'(lat), 64'd34);

    run_op(2'b10, 32'd5, 32'd0, 1'b0, lat, dz, busy_ok);
    check("divzero_latency", 64'(lat), 64'd1);
    check("divzero_flag", {63'd0, dz}, 64'd1);
    check("divzero_hold", {hi, lo}, 64'h0000_0001_0000_0003);

    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, dz, busy_ok);
    check("div_neg_divisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, dz, busy_ok);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);
    check("div_overflow_dz", {63'd0, dz}, 64'd0);

    // Abort a multiply with reset at cycle 10
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    check("abort_no_done", {63'd0, seen_done}, 64'd0);
    $display("[TB] abort: busy=%0d hi=%h lo=%h late_done=%0d", busy, hi, lo, seen_done);

    // Starts while busy must be ignored and not queued
    run_op(2'b00, 32'd6, 32'd7, 1'b1, lat, dz, busy_ok);
    check("ignore_result", {hi, lo}, 64'h0000_0000_0000_002A);
    check("ignore_latency", 64'(lat), 64'd34);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    check("ignore_no_queue", {63'd0, seen_done}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
